// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result drain.
//   drain_state_e : states of the drain sequencer
//   idx_w()       : bit width of a row/column index for an N x N array (never below 1)
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CMP,
      SETTLE,
      SEL,
      WAIT_V,
      OUT,
      GAP,
      DONE
   } drain_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/drain_rowcol_counter.sv
// Row-major (row, col) walker for the drain sequencer.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : return to (0,0)
//   advance  : step to the next PE; the last column wraps to column 0 of the next row
//   row, col : current PE index
//   last     : current PE is (N-1, N-1)
module drain_rowcol_counter
   import systolic_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  advance,
   output logic [idx_w(N)-1:0]   row,
   output logic [idx_w(N)-1:0]   col,
   output logic                  last
);

   localparam int IW = idx_w(N);
   localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

   // Clear has priority over advance; the row also wraps so a stray advance
   // past the final PE can never index outside the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col == MAX_IDX) begin
            col <= '0;
            row <= (row == MAX_IDX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/systolic_result_drain.sv
// Reads the N x N accumulator results out of the systolic array once the
// multiply has finished, one PE at a time in row-major order, and streams
// each C[r][c] out on a valid/ready port.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   start_i                 : one-cycle pulse that arms a drain (ignored while busy)
//   matrix_mult_complete_i  : multiply finished, results are ready to read
//   select_accumulator_o    : one-hot PE select (all zero between PEs)
//   accumulator_valid_i     : per-PE valid; only the selected PE's bit is used
//   row_data_i              : per-row value leaving the selected PE
//   m_valid_o .. m_err_o    : result beat (data, index, last flag, timeout flag)
//   busy_o, done_o, error_o : status; done_o is a 1-cycle pulse, error_o is sticky until start
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int N              = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SETTLE_CYCLES  = 10,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              start_i,
   input  logic                              matrix_mult_complete_i,
   output logic [N-1:0][N-1:0]               select_accumulator_o,
   input  logic [N-1:0][N-1:0]               accumulator_valid_i,
   input  logic [N-1:0][DATA_WIDTH-1:0]      row_data_i,
   output logic                              m_valid_o,
   input  logic                              m_ready_i,
   output logic [DATA_WIDTH-1:0]             m_data_o,
   output logic [idx_w(N)-1:0]               m_row_o,
   output logic [idx_w(N)-1:0]               m_col_o,
   output logic                              m_last_o,
   output logic                              m_err_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              error_o
);

   localparam int IW = idx_w(N);
   localparam int SW = idx_w(SETTLE_CYCLES + 1);
   localparam int TW = idx_w(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);

   drain_state_e        state;
   logic [SW-1:0]       settle_cnt;
   logic [TW-1:0]       timer;
   logic [IW-1:0]       row;
   logic [IW-1:0]       col;
   logic                cnt_last;
   logic                cnt_clear;
   logic                cnt_advance;
   logic [N-1:0][N-1:0] sel_onehot;

   // The counter restarts at (0,0) on every accepted start and steps after
   // each handshake except the final one.
   assign cnt_clear   = (state == IDLE) && start_i;
   assign cnt_advance = (state == OUT) && m_ready_i && !cnt_last;

   drain_rowcol_counter #(
      .N (N)
   ) u_counter (
      .clk     (clk_i),
      .rst     (rst_i),
      .clear   (cnt_clear),
      .advance (cnt_advance),
      .row     (row),
      .col     (col),
      .last    (cnt_last)
   );

   // One-hot select pattern for the current PE, loaded into the select
   // register when the sequencer enters SEL.
   always_comb begin
      sel_onehot           = '0;
      sel_onehot[row][col] = 1'b1;
   end

   // Drain sequencer. The select is raised on the edge that enters SEL, so it
   // is already high during SEL; the timer starts counting there, which makes
   // a missing valid produce its error beat TIMEOUT_CYCLES cycles after select.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state                <= IDLE;
         settle_cnt           <= '0;
         timer                <= '0;
         select_accumulator_o <= '0;
         m_valid_o            <= 1'b0;
         m_data_o             <= '0;
         m_row_o              <= '0;
         m_col_o              <= '0;
         m_last_o             <= 1'b0;
         m_err_o              <= 1'b0;
         busy_o               <= 1'b0;
         done_o               <= 1'b0;
         error_o              <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state   <= WAIT_CMP;
                  busy_o  <= 1'b1;
                  done_o  <= 1'b0;
                  error_o <= 1'b0;
               end
            end
            WAIT_CMP: begin
               if (matrix_mult_complete_i) begin
                  if (SETTLE_CYCLES == 0) begin
                     state                <= SEL;
                     select_accumulator_o <= sel_onehot;
                     timer                <= '0;
                  end else begin
                     state      <= SETTLE;
                     settle_cnt <= '0;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state                <= SEL;
                  select_accumulator_o <= sel_onehot;
                  timer                <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SEL: begin
               state <= WAIT_V;
               timer <= timer + 1'b1;
            end
            WAIT_V: begin
               // A valid arriving on the timeout cycle still wins.
               if (accumulator_valid_i[row][col]) begin
                  state                <= OUT;
                  select_accumulator_o <= '0;
                  m_valid_o            <= 1'b1;
                  m_data_o             <= row_data_i[row];
                  m_row_o              <= row;
                  m_col_o              <= col;
                  m_last_o             <= cnt_last;
                  m_err_o              <= 1'b0;
               end else if (timer >= TIMER_LAST) begin
                  state                <= OUT;
                  select_accumulator_o <= '0;
                  m_valid_o            <= 1'b1;
                  m_data_o             <= '0;
                  m_row_o              <= row;
                  m_col_o              <= col;
                  m_last_o             <= cnt_last;
                  m_err_o              <= 1'b1;
                  error_o              <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            OUT: begin
               if (m_ready_i) begin
                  m_valid_o <= 1'b0;
                  if (cnt_last) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               state                <= SEL;
               select_accumulator_o <= sel_onehot;
               timer                <= '0;
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
